// File: rtl/psum_tile_accumulator.sv
`default_nettype none
// psum_tile_accumulator: accumulates num_tiles partial-sum tiles into a row buffer
// with per-lane signed saturation, then drains the rows over a valid/ready stream. Rev 1.0
module psum_tile_accumulator #(
  parameter int LANES  = 64,
  parameter int PSUM_W = 32,
  parameter int DEPTH  = 64,
  parameter int TILE_W = 8,
  parameter int ROW_W  = $clog2(DEPTH + 1)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      i_start,
  input  logic                      i_abort,
  input  logic [TILE_W-1:0]         i_num_tiles,
  input  logic [ROW_W-1:0]          i_num_rows,
  input  logic                      i_in_valid,
  output logic                      o_in_ready,
  input  logic [LANES*PSUM_W-1:0]   i_in_data,
  output logic                      o_out_valid,
  input  logic                      i_out_ready,
  output logic [LANES*PSUM_W-1:0]   o_out_data,
  output logic                      o_busy,
  output logic                      o_done,
  output logic                      o_sat_flag
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int ROW_BITS = LANES * PSUM_W;
  localparam logic [ROW_W-1:0]  c_ROW_ONE  = 1;
  localparam logic [TILE_W-1:0] c_TILE_ONE = 1;
  localparam logic [PSUM_W-1:0] c_MAX = {1'b0, {(PSUM_W-1){1'b1}}};
  localparam logic [PSUM_W-1:0] c_MIN = {1'b1, {(PSUM_W-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [TILE_W-1:0]   r_num_tiles;
  logic [ROW_W-1:0]    r_num_rows;
  logic [ROW_W-1:0]    r_row;
  logic [TILE_W-1:0]   r_tile;
  logic [ROW_W-1:0]    r_rd;
  logic                r_sat;
  logic [ROW_BITS-1:0] r_buf [DEPTH];

  logic                w_cfg_ok;
  logic                w_start_ok;
  logic                w_beat;
  logic                w_row_last;
  logic                w_tile_last;
  logic                w_out_hs;
  logic                w_rd_last;
  logic [IDX_W-1:0]    w_wr_idx;
  logic [ROW_BITS-1:0] w_cur_row;
  logic [ROW_BITS-1:0] w_acc_row;
  logic [LANES-1:0]    w_lane_sat;

  assign w_cfg_ok    = (i_num_tiles != '0) && (i_num_rows != '0);
  assign w_start_ok  = (r_state == S_IDLE) && i_start && w_cfg_ok && !i_abort;
  assign w_beat      = (r_state == S_ACCUM) && i_in_valid && !i_abort;
  assign w_row_last  = (r_row == r_num_rows - c_ROW_ONE);
  assign w_tile_last = (r_tile == r_num_tiles - c_TILE_ONE);
  assign w_out_hs    = (r_state == S_DRAIN) && i_out_ready && !i_abort;
  assign w_rd_last   = (r_rd == r_num_rows - c_ROW_ONE);
  assign w_wr_idx    = r_row[IDX_W-1:0];
  assign w_cur_row   = r_buf[w_wr_idx];

  // Sum at PSUM_W+1 bits; overflow shows as disagreement of the top two bits.
  for (genvar l = 0; l < LANES; l++) begin : g_lane
    logic [PSUM_W-1:0] w_old;
    logic [PSUM_W-1:0] w_in;
    logic [PSUM_W:0]   w_sum;
    assign w_old = w_cur_row[l*PSUM_W +: PSUM_W];
    assign w_in  = i_in_data[l*PSUM_W +: PSUM_W];
    assign w_sum = {w_old[PSUM_W-1], w_old} + {w_in[PSUM_W-1], w_in};
    assign w_lane_sat[l] = w_sum[PSUM_W] ^ w_sum[PSUM_W-1];
    assign w_acc_row[l*PSUM_W +: PSUM_W] = !w_lane_sat[l] ? w_sum[PSUM_W-1:0] :
                                           (w_sum[PSUM_W] ? c_MIN : c_MAX);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    if (i_abort) begin
      w_next = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:  if (i_start && w_cfg_ok) w_next = S_ACCUM;
        S_ACCUM: if (w_beat && w_row_last && w_tile_last) w_next = S_DRAIN;
        S_DRAIN: if (w_out_hs && w_rd_last) w_next = S_IDLE;
        default: w_next = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_num_tiles <= '0;
      r_num_rows  <= '0;
      r_row       <= '0;
      r_tile      <= '0;
      r_rd        <= '0;
      r_sat       <= 1'b0;
    end else begin
      if (w_start_ok) begin
        r_num_tiles <= i_num_tiles;
        r_num_rows  <= i_num_rows;
        r_row       <= '0;
        r_tile      <= '0;
        r_sat       <= 1'b0;
      end
      if (w_beat) begin
        if (w_row_last) begin
          r_row  <= '0;
          r_tile <= r_tile + c_TILE_ONE;
        end else begin
          r_row <= r_row + c_ROW_ONE;
        end
        if ((r_tile != '0) && (|w_lane_sat)) r_sat <= 1'b1;
        if (w_row_last && w_tile_last) r_rd <= '0;
      end
      if (w_out_hs) r_rd <= r_rd + c_ROW_ONE;
    end
  end

  // Tile 0 overwrites so stale rows from an earlier job never leak in.
  always_ff @(posedge clk) begin
    if (w_beat) r_buf[w_wr_idx] <= (r_tile == '0) ? i_in_data : w_acc_row;
  end

  assign o_in_ready  = (r_state == S_ACCUM);
  assign o_out_valid = (r_state == S_DRAIN);
  assign o_busy      = (r_state != S_IDLE);
  assign o_done      = w_out_hs && w_rd_last;
  assign o_sat_flag  = r_sat;
  assign o_out_data  = o_out_valid ? r_buf[r_rd[IDX_W-1:0]] : '0;

endmodule
`default_nettype wire

// File: tb/tb_psum_tile_accumulator.sv
`default_nettype none
// tb_psum_tile_accumulator: randomized jobs checked against an integer reference model.
// Rev 1.0
module tb_psum_tile_accumulator;

  localparam int LANES = 4;
  localparam int PSUM_W = 16;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_start, i_abort;
  logic [7:0]  i_num_tiles;
  logic [2:0]  i_num_rows;
  logic        i_in_valid, o_in_ready;
  logic [63:0] i_in_data;
  logic        o_out_valid, i_out_ready;
  logic [63:0] o_out_data;
  logic        o_busy, o_done, o_sat_flag;

  int checks = 0;
  int errors = 0;
  int dat [8][4][4];
  int exp_row [4][4];

  psum_tile_accumulator #(.LANES(LANES), .PSUM_W(PSUM_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .i_start(i_start), .i_abort(i_abort),
    .i_num_tiles(i_num_tiles), .i_num_rows(i_num_rows),
    .i_in_valid(i_in_valid), .o_in_ready(o_in_ready), .i_in_data(i_in_data),
    .o_out_valid(o_out_valid), .i_out_ready(i_out_ready), .o_out_data(o_out_data),
    .o_busy(o_busy), .o_done(o_done), .o_sat_flag(o_sat_flag)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] pack_beat(input int t, input int r);
    logic [63:0] v;
    int x;
    for (int l = 0; l < LANES; l++) begin
      x = dat[t][r][l];
      v[l*16 +: 16] = x[15:0];
    end
    return v;
  endfunction

  function automatic logic [63:0] pack_exp(input int r);
    logic [63:0] v;
    int x;
    for (int l = 0; l < LANES; l++) begin
      x = exp_row[r][l];
      v[l*16 +: 16] = x[15:0];
    end
    return v;
  endfunction

  task automatic fill_random(input int nt);
    for (int t = 0; t < nt; t++)
      for (int r = 0; r < 4; r++)
        for (int l = 0; l < LANES; l++)
          dat[t][r][l] = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 65535)) - 32768
                                                     : int'($urandom_range(0, 200)) - 100;
  endtask

  // bp: 0 = ready always, 1 = pattern 1,0,0,..., 2 = random
  task automatic run_job(input int nt, input int nr, input bit gaps, input int bp, input bit noisy);
    bit exp_sat;
    int acc, in_ptr, out_ptr, cyc, last_in, done_cnt;
    bit seen_out, prev_stall;
    logic [63:0] prev_data;
    exp_sat = 0;
    for (int r = 0; r < nr; r++)
      for (int l = 0; l < LANES; l++) begin
        acc = dat[0][r][l];
        for (int t = 1; t < nt; t++) begin
          acc = acc + dat[t][r][l];
          if (acc > 32767) begin acc = 32767; exp_sat = 1; end
          else if (acc < -32768) begin acc = -32768; exp_sat = 1; end
        end
        exp_row[r][l] = acc;
      end
    @(negedge clk);
    i_num_tiles = 8'(nt); i_num_rows = 3'(nr); i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    chk("busy_after_start", {63'd0, o_busy}, 64'd1);
    chk("sat_cleared_on_start", {63'd0, o_sat_flag}, 64'd0);
    in_ptr = 0; out_ptr = 0; cyc = 0; last_in = -10; done_cnt = 0;
    seen_out = 0; prev_stall = 0; prev_data = '0;
    while (out_ptr < nr && cyc < 400) begin
      i_in_valid = (in_ptr < nt*nr) && !(gaps && $urandom_range(0, 2) == 0);
      i_in_data  = (in_ptr < nt*nr) ? pack_beat(in_ptr / nr, in_ptr % nr) : '0;
      i_out_ready = (bp == 0) ? 1'b1 : (bp == 1) ? (cyc % 3 == 0) : 1'($urandom_range(0, 1));
      if (noisy) begin
        i_start = 1'($urandom_range(0, 1));
        i_num_tiles = 8'($urandom_range(0, 3));
        i_num_rows = 3'($urandom_range(0, 4));
      end
      #1;
      if (o_out_valid && !seen_out) begin
        seen_out = 1;
        chk("first_out_latency", 64'(cyc - last_in), 64'd1);
      end
      if (prev_stall) begin
        chk("stall_valid_held", {63'd0, o_out_valid}, 64'd1);
        chk("stall_data_held", o_out_data, prev_data);
      end
      if (o_done) done_cnt++;
      if (o_in_ready && i_in_valid) begin in_ptr++; last_in = cyc; end
      if (o_out_valid && i_out_ready) begin
        chk("row_data", o_out_data, pack_exp(out_ptr));
        chk("done_on_handshake", {63'd0, o_done}, {63'd0, out_ptr == nr - 1});
        out_ptr++;
      end
      prev_stall = o_out_valid && !i_out_ready;
      prev_data = o_out_data;
      @(negedge clk);
      cyc++;
    end
    i_start = 1'b0; i_in_valid = 1'b0; i_out_ready = 1'b0;
    chk("job_no_timeout", {63'd0, cyc >= 400}, 64'd0);
    chk("beats_in", 64'(in_ptr), 64'(nt*nr));
    chk("rows_out", 64'(out_ptr), 64'(nr));
    chk("done_count", 64'(done_cnt), 64'd1);
    chk("busy_after_done", {63'd0, o_busy}, 64'd0);
    chk("sat_flag", {63'd0, o_sat_flag}, {63'd0, exp_sat});
  endtask

  initial begin
    rst = 1'b1; i_start = 0; i_abort = 0; i_num_tiles = 0; i_num_rows = 0;
    i_in_valid = 0; i_in_data = '0; i_out_ready = 0;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", {63'd0, o_in_ready}, 64'd0);
    chk("rst_out_valid", {63'd0, o_out_valid}, 64'd0);
    chk("rst_busy", {63'd0, o_busy}, 64'd0);
    chk("rst_done", {63'd0, o_done}, 64'd0);
    chk("rst_sat", {63'd0, o_sat_flag}, 64'd0);
    chk("rst_out_data", o_out_data, 64'd0);
    rst = 1'b0;

    // single tile, passthrough
    dat[0][0] = '{1, 2, 3, 4};
    dat[0][1] = '{-5, 6, -7, 8};
    run_job(1, 2, 0, 0, 0);

    // three tiles of constant value
    for (int t = 0; t < 3; t++)
      for (int r = 0; r < 4; r++)
        for (int l = 0; l < 4; l++) dat[t][r][l] = 10 * (t + 1);
    run_job(3, 4, 0, 0, 0);

    // saturation at both rails
    dat[0][0] = '{32767, -32768, 100, 0};
    dat[1][0] = '{1, -1, -200, 5};
    run_job(2, 1, 0, 0, 0);

    // constant job again under backpressure and input gaps
    for (int t = 0; t < 3; t++)
      for (int r = 0; r < 4; r++)
        for (int l = 0; l < 4; l++) dat[t][r][l] = 10 * (t + 1);
    run_job(3, 4, 1, 1, 0);

    // zero-field and abort-colliding starts are ignored
    @(negedge clk); i_start = 1; i_num_tiles = 2; i_num_rows = 0;
    @(negedge clk); i_start = 0;
    chk("start_rows0_idle", {63'd0, o_busy}, 64'd0);
    i_start = 1; i_num_tiles = 0; i_num_rows = 2;
    @(negedge clk); i_start = 0;
    chk("start_tiles0_idle", {63'd0, o_busy}, 64'd0);
    i_start = 1; i_abort = 1; i_num_tiles = 1; i_num_rows = 2;
    @(negedge clk); i_start = 0; i_abort = 0;
    chk("abort_beats_start", {63'd0, o_busy}, 64'd0);

    // abort after three accepted beats
    fill_random(2);
    i_start = 1; i_num_tiles = 2; i_num_rows = 4;
    @(negedge clk); i_start = 0;
    for (int b = 0; b < 3; b++) begin
      i_in_valid = 1; i_in_data = pack_beat(0, b);
      #1 chk("abort_job_in_ready", {63'd0, o_in_ready}, 64'd1);
      @(negedge clk);
    end
    i_in_valid = 0; i_abort = 1;
    @(negedge clk); i_abort = 0;
    chk("abort_in_ready", {63'd0, o_in_ready}, 64'd0);
    chk("abort_busy", {63'd0, o_busy}, 64'd0);
    chk("abort_done", {63'd0, o_done}, 64'd0);
    chk("abort_out_valid", {63'd0, o_out_valid}, 64'd0);
    fill_random(2);
    run_job(2, 4, 0, 0, 0);

    // random jobs, with spurious starts while busy
    for (int j = 0; j < 8; j++) begin
      fill_random(4);
      run_job($urandom_range(1, 4), $urandom_range(1, 4), 1'($urandom_range(0, 1)), 2, 1'(j % 2));
    end

    // reset during the second drained row
    fill_random(1);
    @(negedge clk); i_start = 1; i_num_tiles = 1; i_num_rows = 3;
    @(negedge clk); i_start = 0;
    for (int b = 0; b < 3; b++) begin
      i_in_valid = 1; i_in_data = pack_beat(0, b);
      @(negedge clk);
    end
    i_in_valid = 0; i_out_ready = 1;
    #1 chk("rm_row0_valid", {63'd0, o_out_valid}, 64'd1);
    @(negedge clk);
    i_out_ready = 0;
    #1 chk("rm_row1_valid", {63'd0, o_out_valid}, 64'd1);
    rst = 1'b1;
    #1;
    chk("rm_out_valid", {63'd0, o_out_valid}, 64'd0);
    chk("rm_busy", {63'd0, o_busy}, 64'd0);
    chk("rm_done", {63'd0, o_done}, 64'd0);
    chk("rm_out_data", o_out_data, 64'd0);
    @(negedge clk); rst = 1'b0;
    fill_random(3);
    run_job(3, 3, 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/psum_tile_accumulator.md
# psum_tile_accumulator

Parametrised multi-tile partial-sum accumulator placed between the systolic-array compute unit and the output memory subsystem. It holds a buffer of `DEPTH` rows × `LANES` lanes. It accumulates the partial-sum rows streamed out over `num_tiles` consecutive C_in tiles, with signed saturation. It then drains the final rows to memory over a valid/ready stream. This removes the need for memory to feed previous partial sums back into the array.

## Interface
- `LANES`, 64, number of parallel partial-sum lanes (SA columns)
- `PSUM_W`, 32, signed partial-sum/accumulator width per lane
- `DEPTH`, 64, maximum rows per tile held in the buffer
- `TILE_W`, 8, width of the tile-count field
- `ROW_W`, $clog2(DEPTH+1), width of the row-count field

- `clk`  in  1  sole clock, all state rising-edge
- `rst`  in  1  asynchronous, active-high reset
- `start`  in  1  one-cycle pulse; latches config, begins job (IDLE only)
- `abort`  in  1  synchronous clear to IDLE; no output, no done
- `num_tiles`  in  TILE_W  tiles to accumulate, valid 1..2^TILE_W-1
- `num_rows`  in  ROW_W  rows per tile, valid 1..DEPTH
- `in_valid`  in  1  input row valid
- `in_ready`  out  1  accumulator accepts a row
- `in_data`  in  LANES×PSUM_W  signed partial-sum row from the SA
- `out_valid`  out  1  output row valid
- `out_ready`  in  1  downstream accepts a row
- `out_data`  out  LANES×PSUM_W  accumulated row
- `busy`  out  1  state ≠ IDLE
- `done`  out  1  one-cycle pulse on last output handshake
- `sat_flag`  out  1  sticky; any lane saturated during current job

## Operation
- FSM states: IDLE, ACCUM, DRAIN.
- IDLE:
  - `start` with both `num_tiles`≠0 and `num_rows`≠0 latches the config.
  - It clears the row counter, tile counter and `sat_flag`, then moves to ACCUM.
  - `start` with a zero field is ignored; the state stays IDLE.
- ACCUM:
  - Beat accepted when `in_valid`&&`in_ready`.
  - Row r = row counter. In tile 0: buf[r] ← in_data (overwrite, no stale data). In tile ≥1: buf[r] ← sat(buf[r] + in_data) per lane.
  - Row counter increments and wraps to 0 after `num_rows`-1; on wrap, the tile counter increments.
  - On the beat that completes row `num_rows`-1 of tile `num_tiles`-1: go to DRAIN with read pointer 0.
- DRAIN:
  - `out_data` = buf[read pointer].
  - Read pointer advances on each `out_valid`&&`out_ready`.
  - The handshake on row `num_rows`-1 asserts `done` and returns to IDLE.
- Arithmetic:
  - Sum is formed at PSUM_W+1 bits signed.
  - Result is clamped to [−2^(PSUM_W−1), 2^(PSUM_W−1)−1].
  - Any clamp in any lane sets `sat_flag`, which holds until the next accepted `start` or reset.
- `start` outside IDLE is ignored.
- `abort` in any state returns to IDLE next edge. Buffer contents are left untouched; `sat_flag` holds.
- `abort` and `start` in the same IDLE cycle: `abort` wins and the job does not start.

## Timing
- Reset values: `in_ready`=0, `out_valid`=0, `busy`=0, `done`=0, `sat_flag`=0, `out_data`=0, state IDLE, counters 0. Buffer contents are not reset.
- `in_ready` = (state==ACCUM), registered-state derived; no combinational path from `in_valid`.
- Input accepts 1 row/cycle; the buffer write lands on the accepting edge.
- First `out_valid` appears 1 cycle after the last input beat. Throughput is 1 row/cycle with `out_ready` held high.
- `out_valid` and `out_data` are held stable while `out_ready`=0.
- `done` is high in the cycle of the final handshake. `busy` falls the following cycle, and a new `start` is accepted in that cycle.
- Total job latency = `num_rows`×`num_tiles` accepted beats, then `num_rows` drain handshakes.
- `rst` mid-job: all outputs go to their reset values immediately (async); no `done` is issued.

## Test plan
Bench parameters: LANES=4, DEPTH=4, PSUM_W=16.

1. Single tile, no accumulation: `num_tiles`=1, `num_rows`=2; rows {1,2,3,4},{−5,6,−7,8} → drained unchanged; `done` on 2nd handshake; `sat_flag`=0.
2. Multi-tile: `num_tiles`=3, `num_rows`=4; every beat in tile t carries lane value 10·(t+1) → all 4 drained rows = {60,60,60,60}; exactly 12 input beats then 4 output beats.
3. Saturation: `num_tiles`=2, `num_rows`=1; tile 0 row {32767,−32768,100,0}, tile 1 row {1,−1,−200,5} → output {32767,−32768,−100,5}; `sat_flag`=1; next `start` clears it.
4. Backpressure: case 2 with `out_ready` toggling 1,0,0,1… and `in_valid` gapped → identical data; `out_data` stable during stalls; no row lost or duplicated.
5. Illegal/overlapping control: `start` with `num_rows`=0 → stays IDLE, `busy`=0; `start` while in ACCUM → ignored, counters unchanged; `abort` after 3 beats → IDLE next cycle, `in_ready`=0, no `done`; new job then gives correct tile-0 overwrite results.
6. Reset mid-DRAIN: assert `rst` during 2nd output row → `out_valid`, `busy`, `done` drop to 0 immediately; after release a fresh job completes correctly.
